// File: rtl/sap_pkg.sv
// Shared SAP definitions: bus/address/step widths and the host loader FSM encoding.
package sap_pkg;

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [2:0] {
    LD_RUN      = 3'd0,
    LD_DRAIN    = 3'd1,
    LD_GRANT    = 3'd2,
    LD_ADDR     = 3'd3,
    LD_DATA     = 3'd4,
    LD_ACK      = 3'd5,
    LD_WAIT_LOW = 3'd6,
    LD_RELEASE  = 3'd7
  } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Host program loader: freezes the CPU at an instruction boundary, takes the bus,
// performs single MAR/RAM accesses for the host, then restarts the CPU on release.
module prog_loader
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] step_in,
  input  logic              halt_in,
  input  logic              host_sel,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [BUS_W-1:0]  host_wdata,
  input  logic [BUS_W-1:0]  bus_in,
  output logic              host_ack,
  output logic [BUS_W-1:0]  host_rdata,
  output logic              grant,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              bus_oe,
  output logic [BUS_W-1:0]  bus_out,
  output logic              mar_in,
  output logic              ram_in,
  output logic              ram_out
);

  ld_state_t        r_state;
  ld_state_t        w_next;
  logic [BUS_W-1:0] r_rdata;
  logic             w_boundary;

  // The controller is safe to freeze at step 0 or when it has halted.
  assign w_boundary = (step_in == '0) || halt_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LD_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (r_state == LD_DATA && !host_we) begin
      r_rdata <= bus_in;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LD_RUN:      if (host_sel) w_next = LD_DRAIN;
      LD_DRAIN:    if (w_boundary) w_next = LD_GRANT;
      LD_GRANT: begin
        // A pending request takes priority over a simultaneous release.
        if (host_req)       w_next = LD_ADDR;
        else if (!host_sel) w_next = LD_RELEASE;
      end
      LD_ADDR:     w_next = LD_DATA;
      LD_DATA:     w_next = LD_ACK;
      LD_ACK:      w_next = LD_WAIT_LOW;
      LD_WAIT_LOW: if (!host_req) w_next = LD_GRANT;
      LD_RELEASE:  w_next = LD_RUN;
      default:     w_next = LD_RUN;
    endcase
  end

  always_comb begin
    host_ack = 1'b0;
    grant    = 1'b0;
    cpu_hold = 1'b0;
    cpu_rst  = 1'b0;
    bus_oe   = 1'b0;
    bus_out  = '0;
    mar_in   = 1'b0;
    ram_in   = 1'b0;
    ram_out  = 1'b0;
    unique case (r_state)
      LD_RUN: ;
      LD_DRAIN:    cpu_hold = w_boundary;
      LD_GRANT: begin
        grant    = 1'b1;
        cpu_hold = 1'b1;
      end
      LD_ADDR: begin
        grant    = 1'b1;
        cpu_hold = 1'b1;
        bus_oe   = 1'b1;
        bus_out  = {{(BUS_W-ADDR_W){1'b0}}, host_addr};
        mar_in   = 1'b1;
      end
      LD_DATA: begin
        grant    = 1'b1;
        cpu_hold = 1'b1;
        if (host_we) begin
          bus_oe  = 1'b1;
          bus_out = host_wdata;
          ram_in  = 1'b1;
        end else begin
          ram_out = 1'b1;
        end
      end
      LD_ACK: begin
        grant    = 1'b1;
        cpu_hold = 1'b1;
        host_ack = 1'b1;
      end
      LD_WAIT_LOW: begin
        grant    = 1'b1;
        cpu_hold = 1'b1;
      end
      LD_RELEASE: begin
        cpu_hold = 1'b1;
        cpu_rst  = 1'b1;
      end
      default: ;
    endcase
  end

  assign host_rdata = r_rdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized bench for prog_loader against a model RAM and a reference memory.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] step_in = 4'd0;
  logic       halt_in = 1'b0;
  logic       host_sel = 1'b0;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_wdata = 8'd0;
  logic [7:0] bus_in;
  logic       host_ack, grant, cpu_hold, cpu_rst, bus_oe, mar_in, ram_in, ram_out;
  logic [7:0] host_rdata, bus_out;

  prog_loader dut (
    .clk(clk), .rst(rst), .step_in(step_in), .halt_in(halt_in),
    .host_sel(host_sel), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .bus_in(bus_in),
    .host_ack(host_ack), .host_rdata(host_rdata), .grant(grant),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .bus_oe(bus_oe),
    .bus_out(bus_out), .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Physical RAM + MAR seen through the bus strobes; ref_mem is the expected content.
  logic [7:0] env_ram [16];
  logic [7:0] ref_mem [16];
  logic [3:0] env_mar = 4'd0;
  logic [7:0] junk = 8'hA5;
  int ack_cnt = 0, mar_cnt = 0, crst_cnt = 0;
  int n_vec = 0, n_err = 0;
  logic [7:0] last_rd = 8'h00;

  assign bus_in = ram_out ? env_ram[env_mar] : junk;

  always @(posedge clk) begin
    if (mar_in) env_mar <= bus_out[3:0];
    if (ram_in) env_ram[env_mar] <= bus_out;
    if (host_ack) ack_cnt++;
    if (mar_in) mar_cnt++;
    if (cpu_rst) crst_cnt++;
    junk <= 8'($urandom);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {7'd0, host_ack}, 8'd0);
    chk({tag, "_grant"}, {7'd0, grant}, 8'd0);
    chk({tag, "_hold"}, {7'd0, cpu_hold}, 8'd0);
    chk({tag, "_crst"}, {7'd0, cpu_rst}, 8'd0);
    chk({tag, "_strobes"}, {4'd0, bus_oe, mar_in, ram_in, ram_out}, 8'd0);
    chk({tag, "_bus_out"}, bus_out, 8'd0);
    chk({tag, "_rdata"}, host_rdata, 8'd0);
  endtask

  // One full access starting in GRANT; returns to GRANT with req low.
  task automatic access(input logic we, input logic [3:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    tick;
    chk("addr_mar", {7'd0, mar_in}, 8'd1);
    chk("addr_oe", {7'd0, bus_oe}, 8'd1);
    chk("addr_bus", bus_out, {4'd0, a});
    chk("addr_ack", {7'd0, host_ack}, 8'd0);
    tick;
    chk("data_ramin", {7'd0, ram_in}, {7'd0, we});
    chk("data_ramout", {7'd0, ram_out}, {7'd0, !we});
    chk("data_oe", {7'd0, bus_oe}, {7'd0, we});
    chk("data_bus", bus_out, we ? d : 8'd0);
    chk("data_mar", {7'd0, mar_in}, 8'd0);
    tick;
    chk("ack_pulse", {7'd0, host_ack}, 8'd1);
    chk("ack_strobes", {4'd0, bus_oe, mar_in, ram_in, ram_out}, 8'd0);
    if (!we) last_rd = ref_mem[a];
    chk("ack_rdata", host_rdata, last_rd);
    host_req = 1'b0;
    if (we) ref_mem[a] = d;
    tick;
    chk("wait_ack", {7'd0, host_ack}, 8'd0);
    chk("wait_grant", {7'd0, grant}, 8'd1);
    tick;
    chk("back_grant", {7'd0, grant}, 8'd1);
    chk("back_rdata", host_rdata, last_rd);
  endtask

  task automatic acquire(input logic [3:0] step, input logic halt);
    step_in = step; halt_in = halt; host_sel = 1'b1;
    tick;
    tick;
    chk("acq_grant", {7'd0, grant}, 8'd1);
  endtask

  initial begin
    int a0, m0, c0, g;
    for (int i = 0; i < 16; i++) begin
      env_ram[i] = 8'($urandom);
      ref_mem[i] = env_ram[i];
    end
    env_ram[2] = 8'h5E;
    ref_mem[2] = 8'h5E;
    #1;
    chk_all_zero("reset0");
    tick;
    rst = 1'b0;
    tick;
    chk_all_zero("run_idle");

    // Write then read directed cases
    acquire(4'd0, 1'b0);
    access(1'b1, 4'hA, 8'h3C);
    access(1'b0, 4'h2, 8'h00);
    chk("read_5e", host_rdata, 8'h5E);
    access(1'b0, 4'hA, 8'h00);
    access(1'b1, 4'h2, 8'hC3);
    chk("rdata_hold_wr", host_rdata, 8'h3C);

    // Randomized accesses with idle gaps in GRANT
    for (int k = 0; k < 24; k++) begin
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) tick;
      access(1'($urandom), 4'($urandom), 8'($urandom));
    end

    // Held request overlapping a release request; release only from GRANT
    a0 = ack_cnt; m0 = mar_cnt; c0 = crst_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h2;
    last_rd = ref_mem[4'h2];
    for (int j = 0; j < 6; j++) begin
      tick;
      if (j == 2) host_sel = 1'b0;
    end
    chk("held_grant", {7'd0, grant}, 8'd1);
    chk("held_no_crst", {7'd0, cpu_rst}, 8'd0);
    host_req = 1'b0;
    tick;
    chk("held_acks", 8'(ack_cnt - a0), 8'd1);
    chk("held_mars", 8'(mar_cnt - m0), 8'd1);
    chk("held_rdata", host_rdata, last_rd);
    chk("pre_rel_grant", {7'd0, grant}, 8'd1);
    tick;
    chk("rel_crst", {7'd0, cpu_rst}, 8'd1);
    chk("rel_grant", {7'd0, grant}, 8'd0);
    chk("rel_hold", {7'd0, cpu_hold}, 8'd1);
    tick;
    chk("run_crst", {7'd0, cpu_rst}, 8'd0);
    chk("run_hold", {7'd0, cpu_hold}, 8'd0);
    chk("crst_count", 8'(crst_cnt - c0), 8'd1);

    // Drain: CPU mid-instruction, then reaches step 0
    step_in = 4'd3; host_sel = 1'b1;
    tick;
    for (int j = 0; j < 3; j++) begin
      tick;
      chk("drain_hold", {7'd0, cpu_hold}, 8'd0);
      chk("drain_grant", {7'd0, grant}, 8'd0);
      step_in = 4'($urandom_range(1, 15));
    end
    #1;
    chk("drain_hold_nz", {7'd0, cpu_hold}, 8'd0);
    step_in = 4'd0;
    #1;
    chk("drain_hold_z", {7'd0, cpu_hold}, 8'd1);
    chk("drain_grant_z", {7'd0, grant}, 8'd0);
    tick;
    chk("drain_granted", {7'd0, grant}, 8'd1);

    // Release, then drain via halt with a non-zero step
    host_sel = 1'b0;
    tick;
    tick;
    step_in = 4'd5; halt_in = 1'b1; host_sel = 1'b1;
    tick;
    chk("halt_hold", {7'd0, cpu_hold}, 8'd1);
    tick;
    chk("halt_grant", {7'd0, grant}, 8'd1);
    halt_in = 1'b0;

    // Reset during the DATA cycle of a write
    a0 = ack_cnt; c0 = crst_cnt;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'h7; host_wdata = 8'h99;
    tick;
    tick;
    chk("pre_rst_ramin", {7'd0, ram_in}, 8'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick;
    host_req = 1'b0; host_sel = 1'b0;
    rst = 1'b0;
    tick;
    tick;
    chk_all_zero("post_rst");
    chk("rst_no_ack", 8'(ack_cnt - a0), 8'd0);
    chk("rst_no_crst", 8'(crst_cnt - c0), 8'd0);
    last_rd = 8'h00;

    // Back in RUN: a fresh acquisition still works
    acquire(4'd0, 1'b0);
    access(1'b0, 4'hA, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
